tea_stream_ctrl: RTL and testbench

Job sequencer for the 32-round unrolled TEA pipeline. It latches key and mode per job, issues 64-bit blocks into the pipeline only when the result is guaranteed space, and tracks in-flight blocks with a valid shift register. Results are buffered in an output FIFO with valid/ready backpressure. The pipeline itself has no stall, and its mode and key inputs feed every stage, so this block owns all flow control. Mode and key change only when the pipeline is drained.

---
 rtl/tea_stream_ctrl_if.sv | 20 ++
 rtl/tea_stream_ctrl.sv | 172 +++++++++++++++++
 tb/tb_tea_stream_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tea_stream_ctrl_if.sv
// Stream handshake bundle between the TEA job sequencer (slave) and its data source/sink (master).
interface tea_stream_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/tea_stream_ctrl.sv
// Job sequencer and credit-based flow control for a stall-free unrolled TEA pipeline.
// Optional "%PDF-1.6" first-block header check is built when PDF_HDR_CHECK_EN is defined.
module tea_stream_ctrl #(
  parameter int LATENCY    = 32,
  parameter int FIFO_DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cfg_encrypt,
  input  logic [127:0]     cfg_key,
  input  logic [15:0]      cfg_len,
  tea_stream_ctrl_if.slave strm,
  output logic [63:0]      core_block,
  output logic             core_encrypt,
  output logic [127:0]     core_key,
  input  logic [63:0]      core_out,
  output logic             busy,
  output logic             done,
  output logic             hdr_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 2) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  state_e state_q, state_d;

  // Bit 0 tracks the core_block register; the top bit marks core_out valid for capture.
  logic [LATENCY:0]  vld_q, vld_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [15:0]       issued_q, issued_d;
  logic [15:0]       res_cnt_q, res_cnt_d;
  logic [15:0]       len_q, len_d;
  logic [63:0]       core_block_q, core_block_d;
  logic              core_encrypt_q, core_encrypt_d;
  logic [127:0]      core_key_q, core_key_d;
  logic              done_q, done_d;
  logic [64:0]       fifo_mem [FIFO_DEPTH];

  logic in_fire, out_fire, wr_en, wr_last, job_go;

  assign in_fire  = strm.in_valid && strm.in_ready;
  assign out_fire = strm.out_valid && strm.out_ready;
  assign wr_en    = vld_q[LATENCY];
  assign wr_last  = ((res_cnt_q + 16'd1) == len_q);
  assign job_go   = (state_q == IDLE) && start && (cfg_len != 16'd0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (job_go) state_d = RUN;
      RUN:     if (in_fire && ((issued_q + 16'd1) == len_q)) state_d = DRAIN;
      DRAIN:   if (out_fire && strm.out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    strm.in_ready  = (state_q == RUN) && ((fifo_cnt_q + inflight_q) < DEPTH_C)
                     && (issued_q < len_q);
    strm.out_valid = (fifo_cnt_q != '0);
    strm.out_data  = fifo_mem[rd_ptr_q][63:0];
    strm.out_last  = strm.out_valid && fifo_mem[rd_ptr_q][64];
    busy           = (state_q != IDLE);
    done           = done_q;
    core_block     = core_block_q;
    core_encrypt   = core_encrypt_q;
    core_key       = core_key_q;
  end

  always_comb begin
    vld_d          = {vld_q[LATENCY-1:0], in_fire};
    inflight_d     = inflight_q + CW'(in_fire) - CW'(wr_en);
    fifo_cnt_d     = fifo_cnt_q + CW'(wr_en) - CW'(out_fire);
    wr_ptr_d       = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d       = out_fire ? rd_ptr_q + AW'(1) : rd_ptr_q;
    issued_d       = issued_q;
    res_cnt_d      = res_cnt_q;
    len_d          = len_q;
    core_block_d   = core_block_q;
    core_encrypt_d = core_encrypt_q;
    core_key_d     = core_key_q;
    done_d         = 1'b0;
    if ((state_q == IDLE) && start) begin
      if (cfg_len == 16'd0) begin
        done_d = 1'b1;
      end else begin
        len_d          = cfg_len;
        core_encrypt_d = cfg_encrypt;
        core_key_d     = cfg_key;
        issued_d       = 16'd0;
        res_cnt_d      = 16'd0;
      end
    end
    if (in_fire) begin
      core_block_d = strm.in_data;
      issued_d     = issued_q + 16'd1;
    end
    if (wr_en) res_cnt_d = res_cnt_q + 16'd1;
    if ((state_q == DRAIN) && out_fire && strm.out_last) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q          <= '0;
      inflight_q     <= '0;
      fifo_cnt_q     <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      issued_q       <= '0;
      res_cnt_q      <= '0;
      len_q          <= '0;
      core_block_q   <= '0;
      core_encrypt_q <= 1'b0;
      core_key_q     <= '0;
      done_q         <= 1'b0;
    end else begin
      vld_q          <= vld_d;
      inflight_q     <= inflight_d;
      fifo_cnt_q     <= fifo_cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      issued_q       <= issued_d;
      res_cnt_q      <= res_cnt_d;
      len_q          <= len_d;
      core_block_q   <= core_block_d;
      core_encrypt_q <= core_encrypt_d;
      core_key_q     <= core_key_d;
      done_q         <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_ptr_q] <= {wr_last, core_out};
  end

`ifdef PDF_HDR_CHECK_EN
  localparam logic [63:0] PDF_HDR = 64'h2550_4446_2d31_2e36;
  logic hdr_err_q, hdr_err_d;

  // Plaintext is the pipeline input when encrypting and the pipeline output when decrypting.
  always_comb begin
    hdr_err_d = hdr_err_q;
    if (job_go) begin
      hdr_err_d = 1'b0;
    end else begin
      if (in_fire && (issued_q == 16'd0) && core_encrypt_q && (strm.in_data != PDF_HDR))
        hdr_err_d = 1'b1;
      if (wr_en && (res_cnt_q == 16'd0) && !core_encrypt_q && (core_out != PDF_HDR))
        hdr_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hdr_err_q <= 1'b0;
    else     hdr_err_q <= hdr_err_d;
  end

  assign hdr_err = hdr_err_q;
`else
  assign hdr_err = 1'b0;
`endif
endmodule

// File: tb/tb_tea_stream_ctrl.sv
// Randomized self-checking bench for tea_stream_ctrl: a behavioural stand-in pipeline feeds the
// DUT, and a queue of expected results built from accepted inputs is checked at each output.
`timescale 1ns/1ps
module tb_tea_stream_ctrl;
  localparam int LATENCY    = 32;
  localparam int FIFO_DEPTH = 64;
  localparam logic [63:0] PDF_HDR   = 64'h2550_4446_2d31_2e36;
  localparam logic [63:0] MODE_MASK = 64'hF0F0_0F0F_A5A5_5A5A;
`ifdef PDF_HDR_CHECK_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cfg_encrypt = 1'b0;
  logic [127:0] cfg_key = '0;
  logic [15:0]  cfg_len = '0;
  logic [63:0]  core_block, core_out;
  logic         core_encrypt;
  logic [127:0] core_key;
  logic         busy, done, hdr_err;

  tea_stream_ctrl_if bus();

  tea_stream_ctrl #(.LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_encrypt  (cfg_encrypt),
    .cfg_key      (cfg_key),
    .cfg_len      (cfg_len),
    .strm         (bus),
    .core_block   (core_block),
    .core_encrypt (core_encrypt),
    .core_key     (core_key),
    .core_out     (core_out),
    .busy         (busy),
    .done         (done),
    .hdr_err      (hdr_err)
  );

  always #5 clk = ~clk;

  // Stand-in cipher: any key/mode-dependent bijection exposes routing errors.
  function automatic logic [63:0] pipe_fn(input logic [63:0] x, input logic [127:0] k, input logic e);
    return x ^ k[63:0] ^ k[127:64] ^ (e ? MODE_MASK : 64'h0);
  endfunction

  logic [63:0] pipe [LATENCY];
  always @(posedge clk) begin
    pipe[0] <= pipe_fn(core_block, core_key, core_encrypt);
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end
  assign core_out = pipe[LATENCY-1];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [64:0]  exp_q [$];
  logic [64:0]  mon_e;
  int           job_len, acc_cnt, out_cnt, first_out_cyc, last_out_cyc;
  logic [127:0] m_key;
  logic         m_enc;
  logic         exp_hdr;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Handshakes seen at the falling edge complete on the following rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) begin
        if (acc_cnt == 0)
          exp_hdr = m_enc ? (bus.in_data != PDF_HDR)
                          : (pipe_fn(bus.in_data, m_key, 1'b0) != PDF_HDR);
        exp_q.push_back({acc_cnt == job_len - 1, pipe_fn(bus.in_data, m_key, m_enc)});
        acc_cnt++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_spurious_qsize", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", bus.out_data, mon_e[63:0]);
          check("out_last", bus.out_last, mon_e[64]);
        end
        if (out_cnt == 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        out_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic start_job(input int len, input logic enc, input logic [127:0] key);
    job_len = len; m_key = key; m_enc = enc;
    acc_cnt = 0; out_cnt = 0; exp_hdr = 1'b0;
    exp_q.delete();
    start = 1'b1; cfg_len = 16'(len); cfg_encrypt = enc; cfg_key = key;
    tick();
    start = 1'b0; cfg_encrypt = ~enc; cfg_key = rand_key(); cfg_len = 16'($urandom());
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    check(tag, done, 1'b1);
  endtask

  task automatic one_block(input logic enc, input logic [127:0] key, input logic [63:0] data);
    start_job(1, enc, key);
    bus.in_valid = 1'b1; bus.in_data = data; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_done("hdr_job_done", 100);
  endtask

  task automatic run_job(input int len, input logic enc, input int pv, input int pr);
    int k = 0;
    start_job(len, enc, rand_key());
    while (!done && k < 4000) begin
      bus.in_valid  = ($urandom_range(0, 99) < pv);
      bus.in_data   = {$urandom(), $urandom()};
      bus.out_ready = ($urandom_range(0, 99) < pr);
      tick();
      k++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    check("job_done", done, 1'b1);
    check("job_count", out_cnt, len);
    check("job_drained", exp_q.size(), 0);
    check("job_busy", busy, 1'b0);
    check("job_hdr", hdr_err, HDR_EN ? exp_hdr : 1'b0);
    $display("job len=%0d enc=%0d accepted=%0d delivered=%0d", len, enc, acc_cnt, out_cnt);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] key;
    logic [63:0]  data;
    int k, rdy, vcnt;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_last", bus.out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hdr_err", hdr_err, 1'b0);
    check("rst_core_block", core_block, 64'h0);
    check("rst_core_encrypt", core_encrypt, 1'b0);
    check("rst_core_key", core_key, 128'h0);
    rst = 1'b0;
    tick();

    // Zero-length job: done pulse only.
    start = 1'b1; cfg_len = 16'd0; cfg_encrypt = 1'b1;
    tick();
    start = 1'b0;
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    tick();
    check("zero_done_pulse", done, 1'b0);

    // Single block latency.
    key = rand_key(); data = {$urandom(), $urandom()};
    bus.out_ready = 1'b1;
    start_job(1, 1'b1, key);
    check("sb_busy", busy, 1'b1);
    check("sb_enc", core_encrypt, 1'b1);
    check("sb_key", core_key, key);
    bus.in_valid = 1'b1; bus.in_data = data;
    check("sb_in_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    check("sb_core_block", core_block, data);
    check("sb_drain_ready", bus.in_ready, 1'b0);
    k = 0;
    while (!bus.out_valid && k < 60) begin
      tick();
      k++;
    end
    check("sb_latency", k, LATENCY + 1);
    check("sb_out_last", bus.out_last, 1'b1);
    tick();
    check("sb_done", done, 1'b1);
    check("sb_busy_low", busy, 1'b0);
    check("sb_out_valid_low", bus.out_valid, 1'b0);
    tick();
    check("sb_done_pulse", done, 1'b0);

    // Full-rate stream with an ignored start mid-job.
    key = rand_key();
    start_job(100, 1'b1, key);
    rdy = 0;
    for (int i = 0; i < 100; i++) begin
      bus.in_valid = 1'b1; bus.in_data = {$urandom(), $urandom()};
      if (bus.in_ready) rdy++;
      if (i == 50) begin
        start = 1'b1; cfg_encrypt = 1'b0; cfg_key = ~key; cfg_len = 16'd5;
      end
      tick();
      start = 1'b0;
    end
    bus.in_valid = 1'b0;
    check("stream_ready_cycles", rdy, 100);
    check("stream_accepted", acc_cnt, 100);
    check("ign_start_enc", core_encrypt, 1'b1);
    check("ign_start_key", core_key, key);
    check("stream_drain_ready", bus.in_ready, 1'b0);
    wait_done("stream_done", 200);
    check("stream_outputs", out_cnt, 100);
    check("stream_consecutive", last_out_cyc - first_out_cyc, 99);
    $display("job len=100 stream accepted=%0d delivered=%0d", acc_cnt, out_cnt);

    // Backpressure: credits stop intake at FIFO_DEPTH outstanding results.
    start_job(100, 1'b0, rand_key());
    bus.out_ready = 1'b0;
    for (int i = 0; i < 120; i++) begin
      bus.in_valid = 1'b1; bus.in_data = {$urandom(), $urandom()};
      tick();
    end
    check("bp_accepted", acc_cnt, FIFO_DEPTH);
    check("bp_in_ready", bus.in_ready, 1'b0);
    check("bp_out_valid", bus.out_valid, 1'b1);
    k = 0;
    while (!done && k < 2000) begin
      bus.in_data = {$urandom(), $urandom()};
      bus.out_ready = ($urandom_range(0, 1) == 1);
      tick();
      k++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    check("bp_done", done, 1'b1);
    check("bp_outputs", out_cnt, 100);
    $display("job len=100 backpressure accepted=%0d delivered=%0d", acc_cnt, out_cnt);

    // Reset with blocks in flight.
    start_job(100, 1'b1, rand_key());
    bus.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1; bus.in_data = {$urandom(), $urandom()};
      tick();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_in_ready", bus.in_ready, 1'b0);
    rst = 1'b0;
    exp_q.delete(); out_cnt = 0;
    bus.out_ready = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid) vcnt++;
    end
    check("mid_rst_no_outputs", vcnt, 0);

    // Header check.
    key = rand_key();
    one_block(1'b1, key, PDF_HDR);
    check("hdr_enc_match", hdr_err, 1'b0);
    one_block(1'b1, key, 64'h0);
    check("hdr_enc_mismatch", hdr_err, HDR_EN);
    repeat (5) tick();
    check("hdr_sticky", hdr_err, HDR_EN);
    one_block(1'b0, key, PDF_HDR ^ key[63:0] ^ key[127:64]);
    check("hdr_dec_match", hdr_err, 1'b0);
    one_block(1'b0, key, 64'h0123_4567_89ab_cdef);
    check("hdr_dec_mismatch", hdr_err,
          HDR_EN & (pipe_fn(64'h0123_4567_89ab_cdef, key, 1'b0) != PDF_HDR));

    // Random jobs with random valid/ready duty cycles.
    for (int j = 0; j < 6; j++)
      run_job($urandom_range(1, 80), $urandom_range(0, 1) == 1,
              $urandom_range(30, 100), $urandom_range(30, 100));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
